// File: rtl/bsg_tx_if.sv
// bsg_tx_if: handshake/data bundle between the BSG register block and the
// serial transmit engine.
//
// Signals:
//   tx_enable  register block -> engine  BSG_CONTROL[0], level start request
//   data1      register block -> engine  first byte of a frame
//   data2      register block -> engine  second byte of a frame
//   status     engine -> register block  BSG_CONTROL[7:3] {count[2:0], done, busy}
//   tx_out     engine -> pad             serial line, idle high
//
// Modports:
//   master  register-block / testbench side
//   slave   transmit-engine side
interface bsg_tx_if;
  logic       tx_enable;
  logic [7:0] data1;
  logic [7:0] data2;
  logic [4:0] status;
  logic       tx_out;

  modport master (
    output tx_enable,
    output data1,
    output data2,
    input  status,
    input  tx_out
  );

  modport slave (
    input  tx_enable,
    input  data1,
    input  data2,
    output status,
    output tx_out
  );
endinterface

// File: rtl/bsg_tx_engine.sv
// bsg_tx_engine: serial transmit engine for the BSG peripheral.
//
// Serialises a latched {data2, data1} pair as a framed bitstream:
//   start(0), data1 LSB first, data2 LSB first, [even parity], stop(1)
// Every bit is held for CLKS_PER_BIT clocks.
//
// Optional feature macro: BSG_TX_PARITY_EN
//   defined   -> even-parity bit over all 16 data bits after data2 (19-bit frame)
//   undefined -> data2 is followed directly by stop (18-bit frame)
//
// Parameters:
//   CLKS_PER_BIT  clocks per serial bit, 1..65535 (default 16)
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    bsg_tx_if.slave
//            tx_enable  level-sensitive start request (sampled in idle)
//            data1      first byte, latched at frame start
//            data2      second byte, latched at frame start
//            status     [0] busy, [1] done (sticky), [4:2] frame count (wraps)
//            tx_out     serial output, idle high
//
// All outputs come straight from flops; no input reaches an output without
// passing through a register.
module bsg_tx_engine #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input logic     clk,
  input logic     rst_n,
  bsg_tx_if.slave bus
);

  // Last value of the baud counter within one bit period.
  localparam logic [15:0] BaudMax = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData1,
    StData2,
    StParity,
    StStop
  } state_e;

  state_e      state_q;
  logic [15:0] baud_q;
  logic [2:0]  bit_q;
  logic [15:0] shreg_q;
  logic        tx_q;
  logic        busy_q;
  logic        done_q;
  logic [2:0]  count_q;
`ifdef BSG_TX_PARITY_EN
  logic        parity_q;
`endif

  logic bit_end;
  assign bit_end = (baud_q == BaudMax);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= '0;
`ifdef BSG_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          baud_q <= '0;
          bit_q  <= '0;
          tx_q   <= 1'b1;
          if (bus.tx_enable) begin
            // Data is captured here so later register writes cannot corrupt
            // a frame already in flight.
            shreg_q  <= {bus.data2, bus.data1};
`ifdef BSG_TX_PARITY_EN
            parity_q <= ^{bus.data2, bus.data1};
`endif
            done_q   <= 1'b0;
            busy_q   <= 1'b1;
            tx_q     <= 1'b0;
            state_q  <= StStart;
          end
        end

        StStart, StData1, StData2, StParity, StStop: begin
          if (!bit_end) begin
            baud_q <= baud_q + 16'd1;
          end else begin
            baud_q <= '0;
            unique case (state_q)
              StStart: begin
                tx_q    <= shreg_q[0];
                shreg_q <= shreg_q >> 1;
                bit_q   <= '0;
                state_q <= StData1;
              end

              StData1: begin
                // After the eighth data1 bit, shreg_q[0] already holds data2[0].
                tx_q    <= shreg_q[0];
                shreg_q <= shreg_q >> 1;
                bit_q   <= bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                  state_q <= StData2;
                end
              end

              StData2: begin
                shreg_q <= shreg_q >> 1;
                bit_q   <= bit_q + 3'd1;
                if (bit_q == 3'd7) begin
`ifdef BSG_TX_PARITY_EN
                  tx_q    <= parity_q;
                  state_q <= StParity;
`else
                  tx_q    <= 1'b1;
                  state_q <= StStop;
`endif
                end else begin
                  tx_q <= shreg_q[0];
                end
              end

              StParity: begin
                tx_q    <= 1'b1;
                state_q <= StStop;
              end

              StStop: begin
                // busy falls, done rises and the count advances on one edge.
                tx_q    <= 1'b1;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                count_q <= count_q + 3'd1;
                state_q <= StIdle;
              end

              default: state_q <= StIdle;
            endcase
          end
        end

        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx_out = tx_q;
  assign bus.status = {count_q, done_q, busy_q};

endmodule

// File: tb/tb_bsg_tx_engine.sv
// tb_bsg_tx_engine: directed self-checking bench for bsg_tx_engine at
// CLKS_PER_BIT=4. Inputs are driven and outputs sampled on the falling edge.
module tb_bsg_tx_engine;

  localparam int CPB = 4;
`ifdef BSG_TX_PARITY_EN
  localparam int NBITS = 19;
`else
  localparam int NBITS = 18;
`endif
  localparam int FLEN = NBITS * CPB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bsg_tx_if bus ();

  bsg_tx_engine #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Expected line level for bit period i of a frame carrying d1, d2.
  function automatic logic frame_bit(input logic [7:0] d1, input logic [7:0] d2, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return d1[i-1];
    if (i <= 16) return d2[i-9];
`ifdef BSG_TX_PARITY_EN
    if (i == 17) return ^{d1, d2};
`endif
    return 1'b1;
  endfunction

  task automatic test_reset();
    bus.tx_enable = 1'b0;
    bus.data1 = 8'h00;
    bus.data2 = 8'h00;
    rst_n = 1'b0;
    #12;
    vectors++;
    if (bus.tx_out !== 1'b1 || bus.status !== 5'b00000) begin
      miscompares++;
      $display("FAIL reset_held: tx_out=%b status=%b required tx_out=1 status=00000",
               bus.tx_out, bus.status);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.tx_out !== 1'b1 || bus.status !== 5'b00000) begin
      miscompares++;
      $display("FAIL reset_release: tx_out=%b status=%b required tx_out=1 status=00000",
               bus.tx_out, bus.status);
    end
  endtask

  task automatic test_single_frame();
    int errs = 0;
    bus.data1 = 8'hA5;
    bus.data2 = 8'h3C;
    bus.tx_enable = 1'b1;
    @(negedge clk);
    bus.tx_enable = 1'b0;
    for (int c = 0; c < FLEN; c++) begin
      vectors++;
      if (bus.tx_out !== frame_bit(8'hA5, 8'h3C, c / CPB) || bus.status[1:0] !== 2'b01) begin
        miscompares++;
        errs++;
        if (errs < 5)
          $display("FAIL single_frame cyc %0d: tx_out=%b busy/done=%b required tx_out=%b busy/done=01",
                   c, bus.tx_out, bus.status[1:0], frame_bit(8'hA5, 8'h3C, c / CPB));
      end
      @(negedge clk);
    end
    vectors++;
    if (bus.status !== 5'b00110 || bus.tx_out !== 1'b1) begin
      miscompares++;
      $display("FAIL single_frame_end: status=%b tx_out=%b required status=00110 tx_out=1",
               bus.status, bus.tx_out);
    end
    repeat (8) @(negedge clk);
    vectors++;
    if (bus.status !== 5'b00110 || bus.tx_out !== 1'b1) begin
      miscompares++;
      $display("FAIL single_frame_idle: status=%b tx_out=%b required status=00110 tx_out=1",
               bus.status, bus.tx_out);
    end
  endtask

  task automatic test_latching();
    int errs = 0;
    bus.data1 = 8'hA5;
    bus.data2 = 8'h3C;
    bus.tx_enable = 1'b1;
    @(negedge clk);
    bus.tx_enable = 1'b0;
    for (int c = 0; c < FLEN; c++) begin
      if (c == 10) begin
        bus.data1 = 8'hFF;
        bus.data2 = 8'h00;
      end
      vectors++;
      if (bus.tx_out !== frame_bit(8'hA5, 8'h3C, c / CPB)) begin
        miscompares++;
        errs++;
        if (errs < 5)
          $display("FAIL latching cyc %0d: tx_out=%b required %b",
                   c, bus.tx_out, frame_bit(8'hA5, 8'h3C, c / CPB));
      end
      @(negedge clk);
    end
    vectors++;
    if (bus.status !== 5'b01010) begin
      miscompares++;
      $display("FAIL latching_end: status=%b required 01010", bus.status);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_drop_mid_frame();
    int errs = 0;
    bus.data1 = 8'h5A;
    bus.data2 = 8'hC3;
    bus.tx_enable = 1'b1;
    @(negedge clk);
    for (int c = 0; c < FLEN; c++) begin
      if (c == 20) bus.tx_enable = 1'b0;
      vectors++;
      if (bus.tx_out !== frame_bit(8'h5A, 8'hC3, c / CPB) || bus.status[1:0] !== 2'b01) begin
        miscompares++;
        errs++;
        if (errs < 5)
          $display("FAIL drop_mid_frame cyc %0d: tx_out=%b busy/done=%b required tx_out=%b busy/done=01",
                   c, bus.tx_out, bus.status[1:0], frame_bit(8'h5A, 8'hC3, c / CPB));
      end
      @(negedge clk);
    end
    vectors++;
    if (bus.status !== 5'b01110) begin
      miscompares++;
      $display("FAIL drop_mid_frame_end: status=%b required 01110", bus.status);
    end
    repeat (10) @(negedge clk);
    vectors++;
    if (bus.status !== 5'b01110 || bus.tx_out !== 1'b1) begin
      miscompares++;
      $display("FAIL drop_no_restart: status=%b tx_out=%b required status=01110 tx_out=1",
               bus.status, bus.tx_out);
    end
  endtask

  task automatic test_reset_mid_frame();
    int errs = 0;
    bus.data1 = 8'hA5;
    bus.data2 = 8'h3C;
    bus.tx_enable = 1'b1;
    @(negedge clk);
    bus.tx_enable = 1'b0;
    repeat (30) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.tx_out !== 1'b1 || bus.status !== 5'b00000) begin
      miscompares++;
      $display("FAIL reset_mid_frame: tx_out=%b status=%b required tx_out=1 status=00000",
               bus.tx_out, bus.status);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      vectors++;
      if (bus.tx_out !== 1'b1 || bus.status !== 5'b00000) begin
        miscompares++;
        errs++;
        if (errs < 5)
          $display("FAIL reset_quiet cyc %0d: tx_out=%b status=%b required tx_out=1 status=00000",
                   c, bus.tx_out, bus.status);
      end
    end
  endtask

  task automatic test_continuous();
    int errs = 0;
    logic [7:0] d1 = 8'h11;
    logic [7:0] d2 = 8'h80;
    logic [2:0] cnt;
    bus.data1 = d1;
    bus.data2 = d2;
    bus.tx_enable = 1'b1;
    @(negedge clk);
    for (int f = 0; f < 9; f++) begin
      for (int c = 0; c < FLEN; c++) begin
        vectors++;
        if (bus.tx_out !== frame_bit(d1, d2, c / CPB) || bus.status[1:0] !== 2'b01) begin
          miscompares++;
          errs++;
          if (errs < 5)
            $display("FAIL continuous f%0d cyc %0d: tx_out=%b busy/done=%b required tx_out=%b busy/done=01",
                     f, c, bus.tx_out, bus.status[1:0], frame_bit(d1, d2, c / CPB));
        end
        @(negedge clk);
      end
      cnt = 3'(f + 1);
      vectors++;
      if (bus.status !== {cnt, 2'b10}) begin
        miscompares++;
        $display("FAIL continuous_gap f%0d: status=%b required %b", f, bus.status, {cnt, 2'b10});
      end
      // New data presented in the idle gap must be picked up by the next frame.
      d1 = d1 + 8'h13;
      d2 = ~d2;
      bus.data1 = d1;
      bus.data2 = d2;
      if (f == 8) bus.tx_enable = 1'b0;
      @(negedge clk);
    end
    vectors++;
    if (bus.status !== 5'b00110 || bus.tx_out !== 1'b1) begin
      miscompares++;
      $display("FAIL continuous_stop: status=%b tx_out=%b required status=00110 tx_out=1",
               bus.status, bus.tx_out);
    end
  endtask

`ifdef BSG_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] d1s [2] = '{8'h01, 8'h03};
    logic       pexp [2] = '{1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      bus.data1 = d1s[k];
      bus.data2 = 8'h00;
      bus.tx_enable = 1'b1;
      @(negedge clk);
      bus.tx_enable = 1'b0;
      for (int c = 0; c < 76; c++) begin
        if (c == 17 * CPB + 1) begin
          vectors++;
          if (bus.tx_out !== pexp[k]) begin
            miscompares++;
            $display("FAIL parity_bit %0d: tx_out=%b required %b", k, bus.tx_out, pexp[k]);
          end
        end
        if (c == 75) begin
          vectors++;
          if (bus.status[0] !== 1'b1 || bus.tx_out !== 1'b1) begin
            miscompares++;
            $display("FAIL parity_len_last %0d: busy=%b tx_out=%b required busy=1 tx_out=1",
                     k, bus.status[0], bus.tx_out);
          end
        end
        @(negedge clk);
      end
      vectors++;
      if (bus.status[1:0] !== 2'b10) begin
        miscompares++;
        $display("FAIL parity_len_end %0d: busy/done=%b required 10", k, bus.status[1:0]);
      end
      repeat (2) @(negedge clk);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_latching();
    test_drop_mid_frame();
    test_reset_mid_frame();
    test_continuous();
`ifdef BSG_TX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
